// File: rtl/cam.sv
// CAPP associative array: num_cells words with one tag bit each, masked parallel search,
// tag narrowing (set / search / select_first) and multi-write / wired-OR read over tagged cells.
// Optional build macro READ_REG_EN registers read_lines (one extra cycle, resets to 0).

module cam_cell #(
  parameter int unsigned num_bits = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [num_bits-1:0] comparand,
  input  logic [num_bits-1:0] mask,
  input  logic                set,
  input  logic                perform_search,
  input  logic                select_first,
  input  logic                lower_any,
  input  logic [num_bits-1:0] wr_set,
  input  logic [num_bits-1:0] wr_clr,
  output logic                tag_q,
  output logic [num_bits-1:0] word_q
);
  logic                tag_d;
  logic [num_bits-1:0] word_d;
  logic                match;

  // Search compares the word held before this edge, so a coincident write cannot affect it.
  assign match = ~|((word_q ^ comparand) & mask);

  always_comb begin
    tag_d = tag_q;
    if (set)                 tag_d = 1'b1;
    else if (perform_search) tag_d = tag_q & match;
    else if (select_first)   tag_d = tag_q & ~lower_any;
  end

  always_comb begin
    word_d = word_q;
    if (tag_q) word_d = (word_q | wr_set) & ~wr_clr;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tag_q  <= 1'b0;
      word_q <= '0;
    end else begin
      tag_q  <= tag_d;
      word_q <= word_d;
    end
  end
endmodule

module cam #(
  parameter int unsigned num_bits  = 32,
  parameter int unsigned num_cells = 100
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [num_bits-1:0]   comparand,
  input  logic [num_bits-1:0]   mask,
  input  logic                  perform_search,
  input  logic                  set,
  input  logic                  select_first,
  input  logic [2*num_bits-1:0] write_lines,
  output logic [num_cells-1:0]  tag_wires,
  output logic [num_bits-1:0]   read_lines
);
  logic [num_cells-1:0]               tag_q;
  logic [num_cells-1:0][num_bits-1:0] word_q;
  logic [num_cells-1:0]               lower_any;
  logic [num_bits-1:0]                wr_set;
  logic [num_bits-1:0]                wr_clr;
  logic [num_bits-1:0]                read_d;

  // Line pair per bit: [2i] alone sets, [2i+1] alone clears, both/neither hold.
  always_comb begin
    wr_set = '0;
    wr_clr = '0;
    for (int i = 0; i < int'(num_bits); i++) begin
      wr_set[i] = write_lines[2*i]   & ~write_lines[2*i+1];
      wr_clr[i] = write_lines[2*i+1] & ~write_lines[2*i];
    end
  end

  // lower_any[k] = some cell below k is tagged; drives select_first priority.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    lower_any = '0;
    for (int k = 0; k < int'(num_cells); k++) begin
      lower_any[k] = acc;
      acc          = acc | tag_q[k];
    end
  end

  for (genvar k = 0; k < int'(num_cells); k++) begin : g_cell
    cam_cell #(.num_bits(num_bits)) u_cell (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .comparand      (comparand),
      .mask           (mask),
      .set            (set),
      .perform_search (perform_search),
      .select_first   (select_first),
      .lower_any      (lower_any[k]),
      .wr_set         (wr_set),
      .wr_clr         (wr_clr),
      .tag_q          (tag_q[k]),
      .word_q         (word_q[k])
    );
  end

  always_comb begin
    read_d = '0;
    for (int k = 0; k < int'(num_cells); k++)
      if (tag_q[k]) read_d = read_d | word_q[k];
  end

  assign tag_wires = tag_q;

`ifdef READ_REG_EN
  logic [num_bits-1:0] read_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) read_q <= '0;
    else        read_q <= read_d;
  end

  assign read_lines = read_q;
`else
  assign read_lines = read_d;
`endif
endmodule

// File: tb/tb_cam.sv
// Randomized and directed bench for cam against an array-based reference of the tag/word rules.
module tb_cam;
  localparam int NB = 32;
  localparam int NC = 100;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [NB-1:0]   comparand = '0;
  logic [NB-1:0]   mask = '0;
  logic            perform_search = 1'b0;
  logic            set = 1'b0;
  logic            select_first = 1'b0;
  logic [2*NB-1:0] write_lines = '0;
  logic [NC-1:0]   tag_wires;
  logic [NB-1:0]   read_lines;

  cam #(.num_bits(NB), .num_cells(NC)) dut (
    .CLK(CLK), .RST_N(RST_N), .comparand(comparand), .mask(mask),
    .perform_search(perform_search), .set(set), .select_first(select_first),
    .write_lines(write_lines), .tag_wires(tag_wires), .read_lines(read_lines)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [NC-1:0] m_tag;
  logic [NB-1:0] m_word [NC];
  logic [NB-1:0] m_prev_read;

  function automatic logic [NB-1:0] m_read();
    logic [NB-1:0] r = '0;
    for (int k = 0; k < NC; k++) if (m_tag[k]) r |= m_word[k];
    return r;
  endfunction

  function automatic logic [NB-1:0] exp_read();
`ifdef READ_REG_EN
    return m_prev_read;
`else
    return m_read();
`endif
  endfunction

  // Write-line encoding that stores value v: bit 1 -> [2i] high, bit 0 -> [2i+1] high.
  function automatic logic [2*NB-1:0] enc(input logic [NB-1:0] v);
    logic [2*NB-1:0] w = '0;
    for (int i = 0; i < NB; i++) begin
      if (v[i]) w[2*i] = 1'b1;
      else      w[2*i+1] = 1'b1;
    end
    return w;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit past it.
  task automatic step(input logic rst_n, input logic st, input logic srch, input logic sel,
                      input logic [NB-1:0] cmp, input logic [NB-1:0] msk,
                      input logic [2*NB-1:0] wl);
    logic [NC-1:0] nt;
    logic [NB-1:0] nw [NC];
    bit found;
    RST_N = rst_n; set = st; perform_search = srch; select_first = sel;
    comparand = cmp; mask = msk; write_lines = wl;
    m_prev_read = rst_n ? m_read() : '0;
    nt = m_tag;
    nw = m_word;
    if (!rst_n) begin
      nt = '0;
      for (int k = 0; k < NC; k++) nw[k] = '0;
    end else begin
      if (st) nt = '1;
      else if (srch) begin
        for (int k = 0; k < NC; k++) if (((m_word[k] ^ cmp) & msk) != 0) nt[k] = 1'b0;
      end else if (sel) begin
        found = 0;
        for (int k = 0; k < NC; k++) begin
          if (found) nt[k] = 1'b0;
          else if (m_tag[k]) found = 1;
        end
      end
      for (int k = 0; k < NC; k++)
        if (m_tag[k])
          for (int i = 0; i < NB; i++) begin
            if (wl[2*i] && !wl[2*i+1]) nw[k][i] = 1'b1;
            else if (wl[2*i+1] && !wl[2*i]) nw[k][i] = 1'b0;
          end
    end
    @(posedge CLK);
    #1;
    m_tag = nt;
    m_word = nw;
  endtask

  task automatic test_reset();
    step(0, 1, 0, 0, '0, '0, '1);
    step(0, 0, 0, 0, '0, '0, '0);
    checks++;
    if (tag_wires !== '0) begin errors++; $display("FAIL reset_tags got=%h exp=0", tag_wires); end
    checks++;
    if (read_lines !== '0) begin errors++; $display("FAIL reset_read got=%h exp=0", read_lines); end
    step(1, 0, 0, 0, '0, '0, '0);
    step(1, 0, 1, 0, 32'h1234_5678, '1, '0);
    checks++;
    if (tag_wires !== '0) begin errors++; $display("FAIL search_no_tags got=%h exp=0", tag_wires); end
  endtask

  task automatic test_fill_clear();
    step(1, 1, 0, 0, '0, '0, '0);
    step(1, 0, 0, 0, '0, '0, {NB{2'b01}});
    step(1, 0, 0, 0, '0, '0, '0);
    checks++;
    if (tag_wires !== {NC{1'b1}}) begin errors++; $display("FAIL fill_tags got=%h exp=all1", tag_wires); end
    checks++;
    if (read_lines !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fill_read got=%h exp=ffffffff", read_lines); end
    step(1, 0, 0, 0, '0, '0, {NB{2'b10}});
    step(1, 0, 0, 0, '0, '0, '0);
    checks++;
    if (read_lines !== 32'h0) begin errors++; $display("FAIL clear_read got=%h exp=0", read_lines); end
  endtask

  task automatic test_load();
    logic [NC-1:0] one;
    one = 1;
    for (int i = 1; i <= NC; i++) begin
      step(1, 1, 0, 0, '0, '0, '0);
      step(1, 0, 1, 0, '0, '1, '0);
      step(1, 0, 0, 1, '0, '0, '0);
      checks++;
      if (tag_wires !== (one << (i-1)))
        begin errors++; $display("FAIL load_tag i=%0d got=%h exp=%h", i, tag_wires, one << (i-1)); end
      step(1, 0, 0, 0, '0, '0, enc(i));
      step(1, 0, 0, 0, '0, '0, '0);
      checks++;
      if (read_lines !== exp_read())
        begin errors++; $display("FAIL load_read i=%0d got=%h exp=%h", i, read_lines, exp_read()); end
    end
  endtask

  task automatic test_search35();
    logic [NC-1:0] one;
    one = 1;
    step(1, 1, 0, 0, '0, '0, '0);
    step(1, 0, 1, 0, 32'd35, '1, '0);
    step(1, 0, 0, 0, '0, '0, '0);
    checks++;
    if (tag_wires !== (one << 34)) begin errors++; $display("FAIL search35_tags got=%h exp=%h", tag_wires, one << 34); end
    checks++;
    if (read_lines !== 32'd35) begin errors++; $display("FAIL search35_read got=%h exp=23", read_lines); end
  endtask

  task automatic test_masked_search();
    logic [NC-1:0] et;
    logic [NB-1:0] er;
    et = '0; er = '0;
    for (int k = 0; k < NC; k++)
      if (((k+1) >= 32 && (k+1) <= 63) || (k+1) >= 96) begin et[k] = 1'b1; er |= NB'(k+1); end
    step(1, 1, 0, 0, '0, '0, '0);
    step(1, 0, 1, 0, 32'h20, 32'h20, '0);
    step(1, 0, 0, 0, '0, '0, '0);
    checks++;
    if (tag_wires !== et) begin errors++; $display("FAIL mask_search_tags got=%h exp=%h", tag_wires, et); end
    checks++;
    if (read_lines !== er) begin errors++; $display("FAIL mask_search_read got=%h exp=%h", read_lines, er); end
  endtask

  task automatic test_priority_and_empty();
    step(1, 0, 1, 0, 32'hDEAD_0000, '1, '0);
    step(1, 1, 1, 1, 32'hFFFF_0000, '1, '0);
    checks++;
    if (tag_wires !== {NC{1'b1}}) begin errors++; $display("FAIL set_wins got=%h exp=all1", tag_wires); end
    step(1, 0, 1, 1, 32'hDEAD_BEEF, '1, '0);
    checks++;
    if (tag_wires !== '0) begin errors++; $display("FAIL search_wins_over_select got=%h exp=0", tag_wires); end
    step(1, 0, 0, 1, '0, '0, {NB{2'b01}});
    step(1, 0, 0, 0, '0, '0, '0);
    checks++;
    if (tag_wires !== '0) begin errors++; $display("FAIL select_empty got=%h exp=0", tag_wires); end
    checks++;
    if (read_lines !== '0) begin errors++; $display("FAIL empty_read got=%h exp=0", read_lines); end
  endtask

  task automatic test_write_with_search();
    logic [NC-1:0] one;
    one = 1;
    step(1, 1, 0, 0, '0, '0, '0);
    step(1, 0, 1, 0, 32'd35, '1, '0);
    step(1, 0, 1, 0, 32'd35, '1, enc(32'd200));
    checks++;
    if (tag_wires !== (one << 34)) begin errors++; $display("FAIL prewrite_compare got=%h exp=%h", tag_wires, one << 34); end
    step(1, 0, 0, 0, '0, '0, '0);
    checks++;
    if (read_lines !== 32'd200) begin errors++; $display("FAIL write_coincident got=%h exp=c8", read_lines); end
    step(1, 0, 1, 0, 32'd35, '1, '0);
    checks++;
    if (tag_wires !== '0) begin errors++; $display("FAIL post_write_search got=%h exp=0", tag_wires); end
  endtask

  task automatic test_random();
    logic [NB-1:0] cmp, msk;
    logic [2*NB-1:0] wl;
    logic r, st, sr, se;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 59) != 0);
      st = ($urandom_range(0, 5) == 0);
      sr = ($urandom_range(0, 2) == 0);
      se = ($urandom_range(0, 3) == 0);
      cmp = ($urandom_range(0, 1) != 0) ? m_word[$urandom_range(0, NC-1)] : NB'($urandom);
      case ($urandom_range(0, 2))
        0: msk = '1;
        1: msk = NB'($urandom) & NB'($urandom);
        default: msk = NB'($urandom);
      endcase
      wl = ($urandom_range(0, 2) == 0) ? '0 : {32'($urandom), 32'($urandom)};
      step(r, st, sr, se, cmp, msk, wl);
      checks++;
      if (tag_wires !== m_tag) begin errors++; $display("FAIL rand_tags n=%0d got=%h exp=%h", n, tag_wires, m_tag); end
      checks++;
      if (read_lines !== exp_read()) begin errors++; $display("FAIL rand_read n=%0d got=%h exp=%h", n, read_lines, exp_read()); end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 0, 0, '0, '0, '0);
    step(1, 0, 0, 0, '0, '0, {NB{2'b01}});
    step(0, 1, 1, 0, '0, '1, {NB{2'b01}});
    checks++;
    if (tag_wires !== '0) begin errors++; $display("FAIL midreset_tags got=%h exp=0", tag_wires); end
    step(1, 1, 0, 0, '0, '0, '0);
    step(1, 0, 0, 0, '0, '0, '0);
    checks++;
    if (read_lines !== '0) begin errors++; $display("FAIL midreset_words got=%h exp=0", read_lines); end
  endtask

  initial begin
    m_tag = '0;
    m_prev_read = '0;
    for (int k = 0; k < NC; k++) m_word[k] = '0;
    test_reset();
    test_fill_clear();
    test_load();
    test_search35();
    test_masked_search();
    test_priority_and_empty();
    test_write_with_search();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
